// File: rtl/dcmp_w1_encode.sv
// Packs ML-DSA w1 high-part coefficients (4 bits each, 4 lanes per beat) into 64-bit words for the c~ absorb path.
// Optional build macro DCMP_W1_RANGE_CHK_EN adds a sticky range_err_o flag for lanes wider than 4 bits.
module dcmp_w1_encode #(
   parameter int NUM_POLY   = 8,
   parameter int COEFF_IN_W = 6,
   parameter int COEFF_PK_W = 4,
   parameter int LANES      = 4,
   parameter int OUT_W      = 64
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        zeroize,
   input  logic                        start_i,
   input  logic                        mode_i,
   input  logic [LANES*COEFF_IN_W-1:0] w1_i,
   input  logic                        w1_valid_i,
   output logic                        w1_ready_o,
   output logic [OUT_W-1:0]            data_o,
   output logic                        data_valid_o,
   input  logic                        data_ready_i,
   output logic                        data_last_o,
   output logic                        mode_o,
   output logic                        busy_o,
`ifdef DCMP_W1_RANGE_CHK_EN
   output logic                        range_err_o,
`endif
   output logic                        done_o
);

   localparam int BEAT_W         = LANES * COEFF_PK_W;
   localparam int BEATS_PER_WORD = OUT_W / BEAT_W;
   localparam int NUM_WORDS      = NUM_POLY * 256 * COEFF_PK_W / OUT_W;
   localparam int BEAT_CNT_W     = $clog2(BEATS_PER_WORD);
   localparam int WORD_CNT_W     = $clog2(NUM_WORDS);
   localparam int ACC_W          = (BEATS_PER_WORD - 1) * BEAT_W;
   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_WORD - 1);
   localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(NUM_WORDS - 1);

   typedef enum logic {SIGN_OP = 1'b0, VERIFY_OP = 1'b1} dcmp_mode_t;
   typedef enum logic [1:0] {S_IDLE, S_PACK, S_DRAIN} state_t;

   state_t                r_state;
   dcmp_mode_t            r_mode;
   logic [BEAT_CNT_W-1:0] r_beat_cnt;
   logic [WORD_CNT_W-1:0] r_word_cnt;
   logic [ACC_W-1:0]      r_acc;
   logic [OUT_W-1:0]      r_data;
   logic                  r_valid;
   logic                  r_last;
   logic                  r_done;
   logic [BEAT_W-1:0]     w_nib;
   logic                  w_beat_acc;
   logic                  w_out_hs;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_nib = '0;
      for (int j = 0; j < LANES; j++)
         w_nib[j*COEFF_PK_W +: COEFF_PK_W] = w1_i[j*COEFF_IN_W +: COEFF_PK_W];
   end

`ifdef DCMP_W1_RANGE_CHK_EN
   logic r_range_err;
   logic w_hi_err;

   always_comb begin
      w_hi_err = 1'b0;
      for (int j = 0; j < LANES; j++)
         w_hi_err = w_hi_err | (|w1_i[j*COEFF_IN_W+COEFF_PK_W +: COEFF_IN_W-COEFF_PK_W]);
   end

   assign range_err_o = r_range_err;
`else
   logic w_unused_hi;

   always_comb begin
      w_unused_hi = 1'b0;
      for (int j = 0; j < LANES; j++)
         w_unused_hi = w_unused_hi | (|w1_i[j*COEFF_IN_W+COEFF_PK_W +: COEFF_IN_W-COEFF_PK_W]);
   end
`endif

   // The last beat of a word may enter only if the output register is free or emptying this cycle.
   assign w1_ready_o = (r_state == S_PACK) &&
                       ((r_beat_cnt != LAST_BEAT) || !r_valid || data_ready_i);
   assign w_beat_acc = w1_valid_i && w1_ready_o;
   assign w_out_hs   = r_valid && data_ready_i;

   assign data_o       = r_data;
   assign data_valid_o = r_valid;
   assign data_last_o  = r_valid && r_last;
   assign mode_o       = r_mode;
   assign busy_o       = (r_state != S_IDLE);
   assign done_o       = r_done;

   // NOTE: state uses non-blocking assignments only; the accumulator is an ordinary register and is cleared on reset so no stale key material survives.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_mode      <= SIGN_OP;
         r_beat_cnt  <= '0;
         r_word_cnt  <= '0;
         r_acc       <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_last      <= 1'b0;
         r_done      <= 1'b0;
`ifdef DCMP_W1_RANGE_CHK_EN
         r_range_err <= 1'b0;
`endif
      end else if (zeroize) begin
         r_state     <= S_IDLE;
         r_mode      <= SIGN_OP;
         r_beat_cnt  <= '0;
         r_word_cnt  <= '0;
         r_acc       <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_last      <= 1'b0;
         r_done      <= 1'b0;
`ifdef DCMP_W1_RANGE_CHK_EN
         r_range_err <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         if (w_out_hs) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_mode      <= dcmp_mode_t'(mode_i);
                  r_beat_cnt  <= '0;
                  r_word_cnt  <= '0;
                  r_state     <= S_PACK;
`ifdef DCMP_W1_RANGE_CHK_EN
                  r_range_err <= 1'b0;
`endif
               end
            end
            S_PACK: begin
               if (w_beat_acc) begin
`ifdef DCMP_W1_RANGE_CHK_EN
                  if (w_hi_err)
                     r_range_err <= 1'b1;
`endif
                  r_beat_cnt <= r_beat_cnt + 1'b1;
                  if (r_beat_cnt == LAST_BEAT) begin
                     // A load here overrides the handshake clear above: drain and reload in one cycle.
                     r_data     <= {w_nib, r_acc};
                     r_valid    <= 1'b1;
                     r_last     <= (r_word_cnt == LAST_WORD);
                     r_word_cnt <= r_word_cnt + 1'b1;
                     if (r_word_cnt == LAST_WORD)
                        r_state <= S_DRAIN;
                  end else begin
                     for (int b = 0; b < BEATS_PER_WORD - 1; b++)
                        if (r_beat_cnt == BEAT_CNT_W'(b))
                           r_acc[b*BEAT_W +: BEAT_W] <= w_nib;
                  end
               end
            end
            S_DRAIN: begin
               if (w_out_hs) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcmp_w1_encode.sv
// Self-checking bench for dcmp_w1_encode: randomized handshakes against a word-level packing model.
// Define DCMP_W1_RANGE_CHK_EN for both bench and RTL to exercise range_err_o.
module tb_dcmp_w1_encode;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        zeroize;
   logic        start_i;
   logic        mode_i;
   logic [23:0] w1_i;
   logic        w1_valid_i;
   logic        w1_ready_o;
   logic [63:0] data_o;
   logic        data_valid_o;
   logic        data_ready_i;
   logic        data_last_o;
   logic        mode_o;
   logic        busy_o;
   logic        done_o;
`ifdef DCMP_W1_RANGE_CHK_EN
   logic        range_err_o;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [23:0] stim [512];

   // Model state: beats accepted and words handed over in the current vector.
   int   m_beats;
   int   m_out;
   bit   m_active;
   bit   m_done;
   logic m_mode;
   bit   m_rerr;

   dcmp_w1_encode dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .zeroize      (zeroize),
      .start_i      (start_i),
      .mode_i       (mode_i),
      .w1_i         (w1_i),
      .w1_valid_i   (w1_valid_i),
      .w1_ready_o   (w1_ready_o),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .data_ready_i (data_ready_i),
      .data_last_o  (data_last_o),
      .mode_o       (mode_o),
      .busy_o       (busy_o),
`ifdef DCMP_W1_RANGE_CHK_EN
      .range_err_o  (range_err_o),
`endif
      .done_o       (done_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Word n holds beats 4n..4n+3; lane j of beat b lands at bit 16b+4j, low nibble only.
   function automatic logic [63:0] exp_word(input int n);
      logic [63:0] w = '0;
      for (int b = 0; b < 4; b++)
         for (int j = 0; j < 4; j++)
            w = w | (64'(stim[4*n+b][6*j +: 4]) << (16*b + 4*j));
      return w;
   endfunction

   function automatic bit lane_hi(input logic [23:0] v);
      bit e = 0;
      for (int j = 0; j < 4; j++)
         if (v[6*j+4 +: 2] != 2'b00) e = 1;
      return e;
   endfunction

   task automatic gen_stim(input int kind);
      for (int i = 0; i < 512; i++) begin
         if (kind == 1) stim[i] = 24'($urandom);
         else stim[i] = {6'((4*i+3) % 16), 6'((4*i+2) % 16), 6'((4*i+1) % 16), 6'((4*i) % 16)};
      end
      if (kind == 2) stim[7][5:0] = 6'h13;
   endtask

   task automatic model_clear();
      m_beats  = 0;
      m_out    = 0;
      m_active = 0;
      m_done   = 0;
      m_mode   = 1'b0;
      m_rerr   = 0;
   endtask

   initial model_clear();

   // Compare process: outputs are checked on every falling edge against the model.
   always @(negedge clk) begin
      bit exp_valid;
      bit exp_ready;
      if (!reset_n) model_clear();
      exp_valid = (m_beats / 4) > m_out;
      exp_ready = m_active && (m_beats < 512) && ((m_beats % 4) != 3 || !exp_valid || data_ready_i);
      check("data_valid_o", 64'(data_valid_o), 64'(exp_valid));
      check("w1_ready_o", 64'(w1_ready_o), 64'(exp_ready));
      check("data_last_o", 64'(data_last_o), 64'(exp_valid && m_out == 127));
      check("busy_o", 64'(busy_o), 64'(m_active));
      check("done_o", 64'(done_o), 64'(m_done));
      check("mode_o", 64'(mode_o), 64'(m_mode));
      if (exp_valid) check("data_o", data_o, exp_word(m_out));
`ifdef DCMP_W1_RANGE_CHK_EN
      check("range_err_o", 64'(range_err_o), 64'(m_rerr));
`endif
      if (!reset_n || zeroize) model_clear();
      else begin
         m_done = 0;
         if (start_i && !m_active) begin
            m_active = 1;
            m_beats  = 0;
            m_out    = 0;
            m_mode   = mode_i;
            m_rerr   = 0;
         end else if (m_active) begin
            if (w1_valid_i && exp_ready) begin
               if (lane_hi(w1_i)) m_rerr = 1;
               m_beats++;
            end
            if (exp_valid && data_ready_i) begin
               m_out++;
               if (m_out == 128) begin
                  m_active = 0;
                  m_done   = 1;
               end
            end
         end
      end
   end

   // vm: 0 = always valid/ready, 1 = random valid/ready, 2 = stall first word 5 cycles,
   // 3 = stop with the final word held in the output register.
   task automatic run_vec(input logic md, input int vm, input int abort_words,
                          output int cyc, output int nout, output int nlast);
      int idx   = 0;
      int stall = 5;
      bit fin   = 0;
      nout  = 0;
      nlast = 0;
      @(posedge clk); #1;
      cyc = 0;
      start_i = 1'b1; mode_i = md; w1_valid_i = 1'b0; data_ready_i = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      start_i = 1'b0;
      cyc = 1;
      while (!fin) begin
         w1_valid_i   = (idx < 512) && (vm != 1 || $urandom_range(0, 3) != 0);
         w1_i         = (idx < 512) ? stim[idx] : 24'($urandom);
         data_ready_i = (vm == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (vm == 2 && data_valid_o && stall > 0) begin
            data_ready_i = 1'b0;
            stall--;
         end
         if (vm == 3 && idx >= 512) data_ready_i = 1'b0;
         @(negedge clk);
         if (done_o) fin = 1;
         if (w1_valid_i && w1_ready_o) idx++;
         if (data_valid_o && data_ready_i) begin
            nout++;
            if (data_last_o) nlast++;
         end
         if (vm == 3 && idx >= 512 && data_valid_o && !data_ready_i) fin = 1;
         if (abort_words > 0 && nout >= abort_words) fin = 1;
         if (cyc > 4000) begin
            check("driver_timeout", 64'(cyc), 64'd4000);
            fin = 1;
         end
         if (!fin) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      w1_valid_i = 1'b0;
   endtask

   initial begin
      int cyc, nout, nlast;
      reset_n = 1'b0; zeroize = 1'b0; start_i = 1'b0; mode_i = 1'b0;
      w1_i = '0; w1_valid_i = 1'b0; data_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(data_valid_o), 64'd0);
      check("rst_ready", 64'(w1_ready_o), 64'd0);
      check("rst_data", data_o, 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      reset_n = 1'b1;

      // Sign mode, full throughput, ramp pattern.
      gen_stim(0);
      check("model_pin_w0", exp_word(0), 64'hFEDCBA9876543210);
      check("model_pin_w127", exp_word(127), 64'hFEDCBA9876543210);
      run_vec(1'b0, 0, 0, cyc, nout, nlast);
      check("t1_done_cycle", 64'(cyc), 64'd514);
      check("t1_words", 64'(nout), 64'd128);
      check("t1_last_count", 64'(nlast), 64'd1);
      check("t1_mode", 64'(mode_o), 64'd0);

      // Consumer stalls 5 cycles on word 0: only the beat-3 slot waits.
      gen_stim(0);
      run_vec(1'b0, 2, 0, cyc, nout, nlast);
      check("t2_done_cycle", 64'(cyc), 64'd516);
      check("t2_words", 64'(nout), 64'd128);

      // Verify mode, random valid/ready on both sides.
      gen_stim(1);
      run_vec(1'b1, 1, 0, cyc, nout, nlast);
      check("t3_words", 64'(nout), 64'd128);
      check("t3_last_count", 64'(nlast), 64'd1);
      check("t3_mode", 64'(mode_o), 64'd1);

      // Asynchronous reset around word 60, then a clean vector.
      gen_stim(1);
      run_vec(1'b1, 1, 60, cyc, nout, nlast);
      #2 reset_n = 1'b0;
      #1;
      check("t4_rst_valid", 64'(data_valid_o), 64'd0);
      check("t4_rst_busy", 64'(busy_o), 64'd0);
      check("t4_rst_data", data_o, 64'd0);
      check("t4_rst_mode", 64'(mode_o), 64'd0);
      check("t4_rst_done", 64'(done_o), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      gen_stim(0);
      run_vec(1'b0, 0, 0, cyc, nout, nlast);
      check("t4_restart_cycle", 64'(cyc), 64'd514);

      // Zeroize while the final word waits in DRAIN.
      gen_stim(0);
      run_vec(1'b1, 3, 0, cyc, nout, nlast);
      check("t5_pre_busy", 64'(busy_o), 64'd1);
      check("t5_pre_last", 64'(data_last_o), 64'd1);
      @(posedge clk); #1;
      zeroize = 1'b1; data_ready_i = 1'b0;
      @(posedge clk); #1;
      zeroize = 1'b0;
      check("t5_busy", 64'(busy_o), 64'd0);
      check("t5_valid", 64'(data_valid_o), 64'd0);
      check("t5_done", 64'(done_o), 64'd0);
      data_ready_i = 1'b1;
      repeat (4) @(posedge clk);
      #1 check("t5_done_later", 64'(done_o), 64'd0);

`ifdef DCMP_W1_RANGE_CHK_EN
      // Out-of-range lane at beat 7: sticky flag, low nibble still packed.
      gen_stim(2);
      check("model_pin_w1_rng", exp_word(1), 64'hFED3BA9876543210);
      run_vec(1'b0, 0, 0, cyc, nout, nlast);
      check("t6_range_sticky", 64'(range_err_o), 64'd1);
      gen_stim(0);
      run_vec(1'b0, 0, 0, cyc, nout, nlast);
      check("t6_range_cleared", 64'(range_err_o), 64'd0);
`endif

      @(posedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
